// File: rtl/attn_pkg.sv
// Shared width helpers and lane extension for the attention-datapath reduction blocks.
package attn_pkg;

  function automatic int tree_w(input int w, input int lanes);
    return w + $clog2(lanes);
  endfunction

  function automatic int acc_w(input int w, input int lanes, input int max_beats);
    return tree_w(w, lanes) + $clog2(max_beats);
  endfunction

  // Sign- or zero-extends the low w bits of raw to 64 bits; callers truncate to their width.
  function automatic logic [63:0] lane_ext(input logic [63:0] raw, input int w, input bit sgn);
    logic [63:0] r;
    r = raw;
    for (int b = 0; b < 64; b++) begin
      if (b >= w) r[b] = sgn & raw[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level of the reduction tree; valid/last travel with the sums.
module adder_tree_level #(
  parameter int LANES = 2,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LANES*W-1:0]       in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic [(LANES/2)*W-1:0]   out_data,
  output logic                     out_valid,
  output logic                     out_last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

  // Operands are already extended to the full tree width, so the wrap-free sum fits W bits.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int j = 0; j < LANES/2; j++) begin
        out_data[j*W +: W] <= signed'(in_data[(2*j)*W +: W]) + signed'(in_data[(2*j+1)*W +: W]);
      end
    end
  end

endmodule

// File: rtl/pipe_accum_adder_tree.sv
// Pipelined lane-reduction adder tree with per-packet accumulation and full-pipeline stall.
module pipe_accum_adder_tree
  import attn_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH      = 4,
  parameter int SIGNED           = 1,
  parameter int MAX_BEATS        = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]           in_data,
  input  logic                                              in_valid,
  input  logic                                              in_last,
  output logic                                              in_ready,
  output logic [acc_w(INPUT_DATA_WIDTH, DATA_LENGTH, MAX_BEATS)-1:0] out_data,
  output logic                                              out_valid,
  output logic                                              out_ovf,
  input  logic                                              out_ready
);

  localparam int LEVELS = $clog2(DATA_LENGTH);
  localparam int NP     = 1 << LEVELS;
  localparam int TREE_W = tree_w(INPUT_DATA_WIDTH, DATA_LENGTH);
  localparam int ACC_W  = acc_w(INPUT_DATA_WIDTH, DATA_LENGTH, MAX_BEATS);
  localparam int CNT_W  = $clog2(MAX_BEATS + 2);

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // All tree levels packed back to back: level k starts at lane 2*NP - 2*(NP >> k).
  logic [(2*NP-1)*TREE_W-1:0] tree;
  logic [LEVELS:0]            vld_lvl;
  logic [LEVELS:0]            last_lvl;

  // Stage p0: extend lanes and zero-pad up to a power of two.
  for (genvar i = 0; i < NP; i++) begin : g_lane
    if (i < DATA_LENGTH) begin : g_real
      assign tree[i*TREE_W +: TREE_W] = TREE_W'(lane_ext(
          64'(in_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]), INPUT_DATA_WIDTH, SIGNED != 0));
    end else begin : g_pad
      assign tree[i*TREE_W +: TREE_W] = '0;
    end
  end

  assign vld_lvl[0]  = in_valid && in_ready;
  assign last_lvl[0] = in_valid && in_last;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI  = NP >> k;
    localparam int OFI = 2*NP - 2*(NP >> k);
    localparam int OFO = 2*NP - 2*(NP >> (k+1));
    adder_tree_level #(.LANES(NI), .W(TREE_W)) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .en        (!stall),
      .in_data   (tree[OFI*TREE_W +: NI*TREE_W]),
      .in_valid  (vld_lvl[k]),
      .in_last   (last_lvl[k]),
      .out_data  (tree[OFO*TREE_W +: (NI/2)*TREE_W]),
      .out_valid (vld_lvl[k+1]),
      .out_last  (last_lvl[k+1])
    );
  end

  // Accumulator stage: per-packet running sum and beat count.
  logic signed [TREE_W-1:0] tree_sum;
  logic [ACC_W-1:0]         sum_ext;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_next;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  logic                     first;

  assign tree_sum = tree[(2*NP-2)*TREE_W +: TREE_W];

  always_comb begin
    sum_ext  = (SIGNED != 0) ? ACC_W'(tree_sum) : ACC_W'($unsigned(tree_sum));
    acc_next = (first ? '0 : acc) + sum_ext;
    if (first)                            cnt_next = CNT_W'(1);
    else if (cnt == CNT_W'(MAX_BEATS + 1)) cnt_next = cnt;
    else                                  cnt_next = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (vld_lvl[LEVELS]) begin
        if (last_lvl[LEVELS]) begin
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_ovf   <= cnt_next > CNT_W'(MAX_BEATS);
          first     <= 1'b1;
        end else begin
          acc   <= acc_next;
          cnt   <= cnt_next;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_accum_adder_tree.sv
// Directed bench for pipe_accum_adder_tree across signed/unsigned, small MAX_BEATS and odd lane counts.
module tb_pipe_accum_adder_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, ready_a;
  logic [63:0] d_a, d_u, d_o;
  logic [47:0] d_3;
  logic [15:0] d_1;

  logic        rdy_a, rdy_u, rdy_o, rdy_3, rdy_1;
  logic [21:0] od_a, od_u, od_3;
  logic [18:0] od_o;
  logic [19:0] od_1;
  logic        ov_a, ov_u, ov_o, ov_3, ov_1;
  logic        of_a, of_u, of_o, of_3, of_1;

  int errors = 0;
  int checks = 0;

  pipe_accum_adder_tree #(.INPUT_DATA_WIDTH(16), .DATA_LENGTH(4), .SIGNED(1), .MAX_BEATS(16)) dut_a (
    .clk(clk), .rst(rst), .in_data(d_a), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_a),
    .out_data(od_a), .out_valid(ov_a), .out_ovf(of_a), .out_ready(ready_a));
  pipe_accum_adder_tree #(.INPUT_DATA_WIDTH(16), .DATA_LENGTH(4), .SIGNED(0), .MAX_BEATS(16)) dut_u (
    .clk(clk), .rst(rst), .in_data(d_u), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_u),
    .out_data(od_u), .out_valid(ov_u), .out_ovf(of_u), .out_ready(1'b1));
  pipe_accum_adder_tree #(.INPUT_DATA_WIDTH(16), .DATA_LENGTH(4), .SIGNED(1), .MAX_BEATS(2)) dut_o (
    .clk(clk), .rst(rst), .in_data(d_o), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_o),
    .out_data(od_o), .out_valid(ov_o), .out_ovf(of_o), .out_ready(1'b1));
  pipe_accum_adder_tree #(.INPUT_DATA_WIDTH(16), .DATA_LENGTH(3), .SIGNED(1), .MAX_BEATS(16)) dut_3 (
    .clk(clk), .rst(rst), .in_data(d_3), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_3),
    .out_data(od_3), .out_valid(ov_3), .out_ovf(of_3), .out_ready(1'b1));
  pipe_accum_adder_tree #(.INPUT_DATA_WIDTH(16), .DATA_LENGTH(1), .SIGNED(1), .MAX_BEATS(16)) dut_1 (
    .clk(clk), .rst(rst), .in_data(d_1), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_1),
    .out_data(od_1), .out_valid(ov_1), .out_ovf(of_1), .out_ready(1'b1));

  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input longint exp, input int w);
    logic [63:0] e;
    e = 64'(exp) & ((64'd1 << w) - 64'd1);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed='h%0h expected='h%0h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    d_a = d; d_u = d; d_o = d; d_3 = d[47:0]; d_1 = d[15:0];
    in_valid = 1'b1;
    in_last  = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; ready_a = 1'b1;
    d_a = '0; d_u = '0; d_o = '0; d_3 = '0; d_1 = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(ov_a), 0, 1);
    chk("rst_out_data", 64'(od_a), 0, 22);
    chk("rst_out_ovf", 64'(of_a), 0, 1);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 64'(rdy_a), 1, 1);

    // Single beat on every configuration at once.
    d_a = pack4(1, 2, 3, 4);
    d_u = pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    d_o = '0;
    d_3 = 48'h0003_0002_0001;
    d_1 = 16'd9;
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    idle();
    chk("l1_valid_lat1", 64'(ov_1), 1, 1);
    chk("l1_data", 64'(od_1), 9, 20);
    chk("a_not_valid_lat1", 64'(ov_a), 0, 1);
    tick();
    chk("a_not_valid_lat2", 64'(ov_a), 0, 1);
    chk("l1_valid_drops", 64'(ov_1), 0, 1);
    tick();
    chk("a_valid_lat3", 64'(ov_a), 1, 1);
    chk("a_sum_1234", 64'(od_a), 10, 22);
    chk("a_ovf_single", 64'(of_a), 0, 1);
    chk("u_valid_lat3", 64'(ov_u), 1, 1);
    chk("u_sum_ffff", 64'(od_u), 262140, 22);
    chk("l3_valid_lat3", 64'(ov_3), 1, 1);
    chk("l3_sum_123", 64'(od_3), 6, 22);
    tick();
    chk("a_valid_clears", 64'(ov_a), 0, 1);

    // Signed extreme.
    beat(pack4(-32768, -32768, -32768, -32768), 1'b1);
    idle();
    tick(); tick();
    chk("a_valid_min", 64'(ov_a), 1, 1);
    chk("a_sum_min", 64'(od_a), -131072, 22);
    tick();

    // Three-beat packet followed immediately by a one-beat packet.
    beat(pack4(1, 1, 1, 1), 1'b0);
    beat(pack4(2, 2, 2, 2), 1'b0);
    beat(pack4(-1, 0, 0, 0), 1'b1);
    beat(pack4(5, 0, 0, 0), 1'b1);
    idle();
    chk("multi_not_yet", 64'(ov_a), 0, 1);
    tick();
    chk("multi_valid", 64'(ov_a), 1, 1);
    chk("multi_sum", 64'(od_a), 11, 22);
    chk("multi_ovf", 64'(of_a), 0, 1);
    chk("o_sum", 64'(od_o), 11, 19);
    chk("o_ovf_set", 64'(of_o), 1, 1);
    tick();
    chk("next_valid", 64'(ov_a), 1, 1);
    chk("next_sum", 64'(od_a), 5, 22);
    chk("o_next_sum", 64'(od_o), 5, 19);
    chk("o_ovf_clear", 64'(of_o), 0, 1);
    tick();
    chk("next_valid_clears", 64'(ov_a), 0, 1);

    // Backpressure with two packets in flight.
    ready_a = 1'b0;
    beat(pack4(1, 0, 0, 0), 1'b1);
    beat(pack4(2, 0, 0, 0), 1'b1);
    idle();
    tick();
    chk("bp_valid", 64'(ov_a), 1, 1);
    chk("bp_first", 64'(od_a), 1, 22);
    chk("bp_in_ready_low", 64'(rdy_a), 0, 1);
    tick();
    chk("bp_hold_valid", 64'(ov_a), 1, 1);
    chk("bp_hold_first", 64'(od_a), 1, 22);
    chk("bp_hold_in_ready", 64'(rdy_a), 0, 1);
    ready_a = 1'b1;
    tick();
    chk("bp_second_valid", 64'(ov_a), 1, 1);
    chk("bp_second", 64'(od_a), 2, 22);
    tick();
    chk("bp_no_dup", 64'(ov_a), 0, 1);

    // Reset in the middle of a packet.
    beat(pack4(7, 7, 7, 7), 1'b0);
    beat(pack4(7, 7, 7, 7), 1'b0);
    idle();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(ov_a), 0, 1);
    chk("mid_rst_data", 64'(od_a), 0, 22);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 64'(ov_a), 0, 1);
    chk("post_rst_data", 64'(od_a), 0, 22);
    chk("post_rst_ready", 64'(rdy_a), 1, 1);
    beat(pack4(1, 0, 0, 0), 1'b1);
    idle();
    chk("post_rst_lat1", 64'(ov_a), 0, 1);
    tick();
    chk("post_rst_lat2", 64'(ov_a), 0, 1);
    tick();
    chk("post_rst_pkt_valid", 64'(ov_a), 1, 1);
    chk("post_rst_pkt_sum", 64'(od_a), 1, 22);
    chk("post_rst_pkt_ovf", 64'(of_a), 0, 1);
    tick();
    chk("post_rst_clears", 64'(ov_a), 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
